// File: rtl/sio_bus_loader_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sio_bus_loader_pkg                                                       |
// | Opcodes, response defaults and FSM state type for the serial bus loader. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package sio_bus_loader_pkg;

  localparam logic [7:0] OP_WRITE = 8'h57;
  localparam logic [7:0] OP_READ  = 8'h52;
  localparam logic [7:0] OP_GO    = 8'h47;
  localparam logic [7:0] OP_HALT  = 8'h48;

  localparam logic [7:0] ACK_DEFAULT = 8'h4B;
  localparam logic [7:0] NAK_DEFAULT = 8'h3F;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HDR   = 3'd1,
    S_WDATA = 3'd2,
    S_WBUS  = 3'd3,
    S_RBUS  = 3'd4,
    S_RSEND = 3'd5,
    S_RESP  = 3'd6,
    S_RUN   = 3'd7
  } state_t;

endpackage
`default_nettype wire

// File: rtl/sio_bus_loader_cycle.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sio_bus_loader_cycle                                                     |
// | Drives one mreq+rd/wr window of BUS_CYCLES clocks per start pulse and    |
// | returns a one-clock done with the byte sampled on the last read clock.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module sio_bus_loader_cycle #(
  parameter int BUS_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       is_read,
  input  logic [7:0] din,
  output logic       mreq,
  output logic       rd,
  output logic       wr,
  output logic       done,
  output logic [7:0] rdata
);

  localparam int CW = (BUS_CYCLES > 1) ? $clog2(BUS_CYCLES) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      mreq  <= 1'b0;
      rd    <= 1'b0;
      wr    <= 1'b0;
      done  <= 1'b0;
      rdata <= 8'h00;
      cnt   <= '0;
    end else begin
      done <= 1'b0;
      if (mreq) begin
        if (cnt == CW'(BUS_CYCLES - 1)) begin
          mreq <= 1'b0;
          rd   <= 1'b0;
          wr   <= 1'b0;
          done <= 1'b1;
          if (rd) rdata <= din;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else if (start) begin
        mreq <= 1'b1;
        rd   <= is_read;
        wr   <= ~is_read;
        cnt  <= '0;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/sio_bus_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sio_bus_loader                                                           |
// | SIO-driven memory bus initiator holding the CPU in reset while loading.  |
// | Option: SIO_BUS_LOADER_CHECKSUM_EN adds a data sum byte before the ACK.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module sio_bus_loader
  import sio_bus_loader_pkg::*;
#(
  parameter int         BUS_CYCLES = 2,
  parameter logic [7:0] ACK_BYTE   = ACK_DEFAULT,
  parameter logic [7:0] NAK_BYTE   = NAK_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [15:0] adr,
  output logic        mreq,
  output logic        rd,
  output logic        wr,
  output logic [7:0]  bus_dout,
  input  logic [7:0]  bus_din,
  output logic        cpu_hold,
  output logic        overrun
);

  state_t      state, next_state;
  logic [7:0]  opcode;
  logic [1:0]  hdr_cnt;
  logic [15:0] adr_q, len;
  logic [7:0]  dout_q;
  logic        go_pending, launched, start, tx_hs;
  logic        cyc_mreq, cyc_rd, cyc_wr, cyc_done;
  logic [7:0]  cyc_rdata;
  logic        chk_pending;
  logic [7:0]  data_resp;

  assign tx_hs = tx_valid & tx_ready;

  sio_bus_loader_cycle #(.BUS_CYCLES(BUS_CYCLES)) u_cycle (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .is_read (state == S_RBUS),
    .din     (bus_din),
    .mreq    (cyc_mreq),
    .rd      (cyc_rd),
    .wr      (cyc_wr),
    .done    (cyc_done),
    .rdata   (cyc_rdata)
  );

  // Bus is released (all zero) whenever the CPU runs.
  assign adr      = cpu_hold ? adr_q : 16'h0000;
  assign bus_dout = cpu_hold ? dout_q : 8'h00;
  assign mreq     = cpu_hold & cyc_mreq;
  assign rd       = cpu_hold & cyc_rd;
  assign wr       = cpu_hold & cyc_wr;

  always_comb begin
    next_state = state;
    start      = 1'b0;
    case (state)
      S_IDLE:
        if (rx_valid)
          next_state = (rx_data == OP_WRITE || rx_data == OP_READ) ? S_HDR : S_RESP;
      S_HDR:
        if (rx_valid && hdr_cnt == 2'd3) begin
          if ({len[15:8], rx_data} == 16'd0) next_state = S_RESP;
          else if (opcode == OP_WRITE)       next_state = S_WDATA;
          else                               next_state = S_RBUS;
        end
      S_WDATA: if (rx_valid) next_state = S_WBUS;
      S_WBUS: begin
        start = ~launched;
        if (cyc_done) next_state = (len == 16'd1) ? S_RESP : S_WDATA;
      end
      S_RBUS: begin
        start = ~launched;
        if (cyc_done) next_state = S_RSEND;
      end
      S_RSEND: if (tx_hs) next_state = (len == 16'd1) ? S_RESP : S_RBUS;
      S_RESP:  if (tx_hs && !chk_pending) next_state = go_pending ? S_RUN : S_IDLE;
      S_RUN:   if (rx_valid && rx_data == OP_HALT) next_state = S_RESP;
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      opcode     <= 8'h00;
      hdr_cnt    <= 2'd0;
      adr_q      <= 16'h0000;
      len        <= 16'h0000;
      dout_q     <= 8'h00;
      go_pending <= 1'b0;
      launched   <= 1'b0;
      tx_valid   <= 1'b0;
      tx_data    <= 8'h00;
      cpu_hold   <= 1'b1;
      overrun    <= 1'b0;
    end else begin
      state <= next_state;
      if (rx_valid && (state == S_WBUS || state == S_RBUS ||
                       state == S_RSEND || state == S_RESP))
        overrun <= 1'b1;
      if (start)         launched <= 1'b1;
      else if (cyc_done) launched <= 1'b0;

      case (state)
        S_IDLE:
          if (rx_valid) begin
            opcode     <= rx_data;
            hdr_cnt    <= 2'd0;
            go_pending <= (rx_data == OP_GO);
            if (rx_data != OP_WRITE && rx_data != OP_READ) begin
              tx_valid <= 1'b1;
              tx_data  <= (rx_data == OP_GO) ? ACK_BYTE : NAK_BYTE;
            end
          end
        S_HDR:
          if (rx_valid) begin
            hdr_cnt <= hdr_cnt + 2'd1;
            case (hdr_cnt)
              2'd0: adr_q[15:8] <= rx_data;
              2'd1: adr_q[7:0]  <= rx_data;
              2'd2: len[15:8]   <= rx_data;
              default: begin
                len[7:0] <= rx_data;
                if ({len[15:8], rx_data} == 16'd0) begin
                  tx_valid <= 1'b1;
                  tx_data  <= ACK_BYTE;
                end
              end
            endcase
          end
        S_WDATA: if (rx_valid) dout_q <= rx_data;
        S_WBUS:
          if (cyc_done) begin
            adr_q <= adr_q + 16'd1;
            len   <= len - 16'd1;
            if (len == 16'd1) begin
              tx_valid <= 1'b1;
              tx_data  <= data_resp;
            end
          end
        S_RBUS:
          if (cyc_done) begin
            tx_valid <= 1'b1;
            tx_data  <= cyc_rdata;
          end
        S_RSEND:
          if (tx_hs) begin
            adr_q <= adr_q + 16'd1;
            len   <= len - 16'd1;
            if (len == 16'd1) tx_data <= data_resp;
            else              tx_valid <= 1'b0;
          end
        S_RESP:
          if (tx_hs) begin
            if (chk_pending) begin
              tx_data <= ACK_BYTE;
            end else begin
              tx_valid <= 1'b0;
              if (go_pending) cpu_hold <= 1'b0;
            end
          end
        S_RUN:
          if (rx_valid && rx_data == OP_HALT) begin
            cpu_hold   <= 1'b1;
            go_pending <= 1'b0;
            tx_valid   <= 1'b1;
            tx_data    <= ACK_BYTE;
          end
        default: ;
      endcase
    end
  end

`ifdef SIO_BUS_LOADER_CHECKSUM_EN
  logic [7:0] sum;

  always_ff @(posedge clk) begin
    if (rst) begin
      sum         <= 8'h00;
      chk_pending <= 1'b0;
    end else begin
      if (state == S_IDLE && rx_valid)       sum <= 8'h00;
      else if (state == S_WDATA && rx_valid) sum <= sum + rx_data;
      else if (state == S_RBUS && cyc_done)  sum <= sum + cyc_rdata;
      // Only data-carrying commands end in WBUS/RSEND, so only they get a sum byte.
      if (next_state == S_RESP && (state == S_WBUS || state == S_RSEND))
        chk_pending <= 1'b1;
      else if (state == S_RESP && tx_hs)
        chk_pending <= 1'b0;
    end
  end

  assign data_resp = sum;
`else
  assign chk_pending = 1'b0;
  assign data_resp   = ACK_BYTE;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sio_bus_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_sio_bus_loader                                                        |
// | Directed self-checking bench: memory model, bus and tx monitors.         |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_sio_bus_loader;

`ifdef SIO_BUS_LOADER_CHECKSUM_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic [15:0] adr;
  logic        mreq, rd, wr;
  logic [7:0]  bus_dout;
  logic [7:0]  bus_din = 8'h00;
  logic        cpu_hold, overrun;

  int checks = 0;
  int failures = 0;

  logic [7:0]  mem [0:65535];
  logic [7:0]  tx_q[$];
  logic [7:0]  exp_q[$];
  logic [15:0] w_adr[$];
  logic [7:0]  w_dat[$];
  int          w_len[$];
  int          viol = 0;
  int          wr_unstable = 0;
  int          tx_unstable = 0;
  int          wr_run = 0;
  logic [15:0] wa = 16'h0;
  logic [7:0]  wd = 8'h0;
  logic        prev_stall = 1'b0;
  logic [7:0]  prev_txd = 8'h0;

  always #5 clk = ~clk;

  sio_bus_loader dut (
    .clk      (clk),
    .rst      (rst),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .adr      (adr),
    .mreq     (mreq),
    .rd       (rd),
    .wr       (wr),
    .bus_dout (bus_dout),
    .bus_din  (bus_din),
    .cpu_hold (cpu_hold),
    .overrun  (overrun)
  );

  // Synchronous memory (one clock read latency) plus protocol monitors.
  always @(posedge clk) begin
    if (mreq && wr) mem[adr] <= bus_dout;
    if (mreq && rd) bus_din <= mem[adr];
    if ((rd && wr) || (mreq && !rd && !wr) || ((rd || wr) && !mreq)) viol <= viol + 1;
    if (wr) begin
      if (wr_run > 0 && (adr != wa || bus_dout != wd)) wr_unstable <= wr_unstable + 1;
      wa <= adr;
      wd <= bus_dout;
      wr_run <= wr_run + 1;
    end else if (wr_run > 0) begin
      w_adr.push_back(wa);
      w_dat.push_back(wd);
      w_len.push_back(wr_run);
      wr_run <= 0;
    end
    if (tx_valid && !tx_ready) begin
      if (prev_stall && tx_data != prev_txd) tx_unstable <= tx_unstable + 1;
      prev_stall <= 1'b1;
      prev_txd <= tx_data;
    end else begin
      prev_stall <= 1'b0;
    end
    if (tx_valid && tx_ready) tx_q.push_back(tx_data);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_hdr(input logic [7:0] op, input logic [15:0] a, input logic [15:0] n);
    send_byte(op, 8);
    send_byte(a[15:8], 8);
    send_byte(a[7:0], 8);
    send_byte(n[15:8], 8);
    send_byte(n[7:0], 8);
  endtask

  task automatic exp_data_resp(input logic [7:0] s);
    if (CHK) exp_q.push_back(s);
    exp_q.push_back(8'h4B);
  endtask

  task automatic expect_tx(input string tag);
    int k = 0;
    logic [31:0] got;
    while (tx_q.size() < exp_q.size() && k < 3000) begin
      @(negedge clk);
      k++;
    end
    repeat (20) @(negedge clk);
    check($sformatf("%s_count", tag), tx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      got = (i < tx_q.size()) ? {24'h0, tx_q[i]} : 32'hDEAD;
      check($sformatf("%s_b%0d", tag, i), got, {24'h0, exp_q[i]});
    end
    tx_q.delete();
    exp_q.delete();
  endtask

  task automatic expect_write(input string tag, input int i, input logic [15:0] a,
                              input logic [7:0] d);
    logic [31:0] got;
    got = (i < w_adr.size()) ? {w_adr[i], w_dat[i], w_len[i][7:0]} : 32'hDEAD;
    check(tag, got, {a, d, 8'd2});
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_hold", cpu_hold, 1);
    check("rst_bus", {adr, mreq, rd, wr, bus_dout}, 0);
    check("rst_tx", {tx_valid, tx_data, overrun}, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Write two bytes at 8000
    send_hdr(8'h57, 16'h8000, 16'd2);
    send_byte(8'hAA, 8);
    send_byte(8'h55, 8);
    exp_data_resp(8'hFF);
    expect_tx("w8000");
    check("w8000_nwr", w_adr.size(), 2);
    expect_write("w8000_0", 0, 16'h8000, 8'hAA);
    expect_write("w8000_1", 1, 16'h8001, 8'h55);
    w_adr.delete(); w_dat.delete(); w_len.delete();

    // Read them back
    send_hdr(8'h52, 16'h8000, 16'd2);
    exp_q.push_back(8'hAA);
    exp_q.push_back(8'h55);
    exp_data_resp(8'hFF);
    expect_tx("r8000");

    // Address wrap
    send_hdr(8'h57, 16'hFFFF, 16'd2);
    send_byte(8'h11, 8);
    send_byte(8'h22, 8);
    exp_data_resp(8'h33);
    expect_tx("wwrap");
    check("wwrap_nwr", w_adr.size(), 2);
    expect_write("wwrap_0", 0, 16'hFFFF, 8'h11);
    expect_write("wwrap_1", 1, 16'h0000, 8'h22);
    w_adr.delete(); w_dat.delete(); w_len.delete();

    // Zero length: ACK only
    send_hdr(8'h52, 16'h0000, 16'd0);
    exp_q.push_back(8'h4B);
    expect_tx("rzero");

    // Unknown opcode, then GO
    send_byte(8'h00, 8);
    exp_q.push_back(8'h3F);
    expect_tx("nak");
    check("nak_hold", cpu_hold, 1);
    send_byte(8'h47, 8);
    exp_q.push_back(8'h4B);
    expect_tx("go");
    check("run_hold", cpu_hold, 0);
    check("run_bus", {adr, mreq, rd, wr, bus_dout}, 0);
    send_byte(8'h11, 8);
    exp_q.delete();
    expect_tx("run_ignore");
    check("run_no_overrun", overrun, 0);
    send_byte(8'h48, 8);
    exp_q.push_back(8'h4B);
    expect_tx("halt");
    check("halt_hold", cpu_hold, 1);

    // Transmit stall during read, with a dropped rx byte
    tx_ready = 1'b0;
    send_hdr(8'h52, 16'h8000, 16'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("stall_hold%0d", i), {tx_valid, tx_data}, {1'b1, 8'hAA});
    end
    send_byte(8'h99, 2);
    check("stall_overrun", overrun, 1);
    tx_ready = 1'b1;
    exp_q.push_back(8'hAA);
    exp_data_resp(8'hAA);
    expect_tx("rstall");
    check("stall_stable", tx_unstable, 0);

    // Reset during a write window
    send_hdr(8'h57, 16'h1234, 16'd1);
    send_byte(8'h77, 0);
    begin
      int k = 0;
      while (!wr && k < 100) begin
        @(negedge clk);
        k++;
      end
    end
    check("wbus_reached", wr, 1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_strobes", {mreq, rd, wr}, 0);
    check("midrst_hold_ovr", {cpu_hold, overrun}, 2'b10);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    tx_q.delete();
    w_adr.delete(); w_dat.delete(); w_len.delete();
    send_hdr(8'h52, 16'h0000, 16'd1);
    exp_q.push_back(8'h22);
    exp_data_resp(8'h22);
    expect_tx("r0000");

    check("bus_protocol", viol, 0);
    check("wr_stable", wr_unstable, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
